mod_wait_data_mem: RTL and testbench

MOD_WAIT_DATA_MEM -- requirements
Module: mod_wait_data_mem

---
 rtl/mod_wait_data_mem.sv | 175 +++++++++++++++++
 tb/tb_mod_wait_data_mem.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_wait_data_mem.sv
// Word-addressed data memory with a fixed number of wait states per access.
// The processor is stalled through 'hold' while an access is in flight. A dump
// mode streams the whole array out one word per cycle.
module mod_wait_data_mem #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              mem_access_addr,
    input  logic [DATA_W-1:0]        mem_write_data,
    input  logic [DATA_W/8-1:0]      byte_en,
    input  logic                     dump_req,
    output logic [DATA_W-1:0]        mem_read_data,
    output logic                     hold,
    output logic                     rd_valid,
    output logic                     addr_err,
    output logic                     dump_valid,
    output logic [$clog2(DEPTH)-1:0] dump_addr,
    output logic [DATA_W-1:0]        dump_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        DUMP = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        cnt;
    logic [AW-1:0]     word_q;
    logic              oor_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;

    // Array contents are not reset; zero-initialised for simulation.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic req;
    logic finish;
    logic dump_last;
    logic unused_addr_bits;

    assign req       = mem_read | mem_write;
    // The counter reaches 0 on the edge that ends the last stall cycle; with
    // the IDLE request cycle included, hold is high for LATENCY cycles.
    assign finish    = (state == BUSY) && (cnt <= 4'd1);
    assign dump_last = (dump_addr == AW'(DEPTH - 1));

    // Byte offset bits are ignored: accesses are always whole-word aligned.
    assign unused_addr_bits = ^mem_access_addr[1:0];

    // Stall the processor whenever an access or dump is pending or running.
    assign hold = (state == BUSY) || (state == DUMP) || ((state == IDLE) && req);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: an access request always wins over a dump request.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = BUSY;
                end else if (dump_req) begin
                    next_state = DUMP;
                end
            end
            BUSY: begin
                if (finish) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // The processor still presents the finished access here.
                next_state = IDLE;
            end
            DUMP: begin
                if (dump_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Access capture, wait counting, read data return and dump streaming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            word_q        <= '0;
            oor_q         <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            be_q          <= '0;
            mem_read_data <= '0;
            rd_valid      <= 1'b0;
            addr_err      <= 1'b0;
            dump_valid    <= 1'b0;
            dump_addr     <= '0;
            dump_data     <= '0;
        end else begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        word_q  <= mem_access_addr[AW+1:2];
                        oor_q   <= |mem_access_addr[31:AW+2];
                        write_q <= mem_write;
                        wdata_q <= mem_write_data;
                        be_q    <= byte_en;
                        cnt     <= CNT_LOAD;
                    end else if (dump_req) begin
                        dump_valid <= 1'b1;
                        dump_addr  <= '0;
                        dump_data  <= mem[0];
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                    if (finish) begin
                        addr_err <= oor_q;
                        if (!write_q) begin
                            rd_valid      <= 1'b1;
                            mem_read_data <= oor_q ? '0 : mem[word_q];
                        end
                    end
                end
                DUMP: begin
                    if (dump_last) begin
                        dump_valid <= 1'b0;
                    end else begin
                        dump_addr <= dump_addr + AW'(1);
                        dump_data <= mem[dump_addr + AW'(1)];
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-lane write commit at the end of the wait period; out-of-range
    // writes are dropped.
    always_ff @(posedge clk) begin
        if (finish && write_q && !oor_q) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_wait_data_mem.sv
// Scoreboard bench for mod_wait_data_mem (DATA_W=32, DEPTH=16, LATENCY=2).
module tb_mod_wait_data_mem;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  byte_en;
    logic        dump_req;
    logic [31:0] mem_read_data;
    logic        hold;
    logic        rd_valid;
    logic        addr_err;
    logic        dump_valid;
    logic [3:0]  dump_addr;
    logic [31:0] dump_data;

    mod_wait_data_mem #(.DATA_W(32), .DEPTH(16), .LATENCY(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .byte_en         (byte_en),
        .dump_req        (dump_req),
        .mem_read_data   (mem_read_data),
        .hold            (hold),
        .rd_valid        (rd_valid),
        .addr_err        (addr_err),
        .dump_valid      (dump_valid),
        .dump_addr       (dump_addr),
        .dump_data       (dump_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic        err;
        logic [31:0] data;
    } acc_t;

    acc_t        q_acc[$];
    logic [31:0] q_dd[$];
    logic [3:0]  q_da[$];
    logic [31:0] model [16];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every DUT response against the scoreboard queues.
    always @(negedge clk) begin
        if (reset) begin
            if (rd_valid || addr_err) begin
                if (q_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access_pulse rd_valid=%b addr_err=%b data=%h", rd_valid, addr_err, mem_read_data);
                end else begin
                    acc_t e;
                    e = q_acc.pop_front();
                    check("rd_valid", {31'b0, rd_valid}, {31'b0, e.is_read});
                    check("addr_err", {31'b0, addr_err}, {31'b0, e.err});
                    if (e.is_read) check("rd_data", mem_read_data, e.data);
                end
            end
            if (dump_valid) begin
                if (q_dd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dump_word addr=%h data=%h", dump_addr, dump_data);
                end else begin
                    logic [31:0] ed;
                    logic [3:0]  ea;
                    ed = q_dd.pop_front();
                    ea = q_da.pop_front();
                    check("dump_addr", {28'b0, dump_addr}, {28'b0, ea});
                    check("dump_data", dump_data, ed);
                end
            end
        end
    end

    // Issue one access starting just after a rising edge; returns the number
    // of cycles hold was high. Ends just after the DONE->IDLE edge.
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_data, input logic exp_err,
                          output int hc);
        acc_t e;
        bit   done;
        if (rd && !wr) begin
            e.is_read = 1'b1; e.err = exp_err; e.data = exp_data;
            q_acc.push_back(e);
        end else if (exp_err) begin
            e.is_read = 1'b0; e.err = 1'b1; e.data = '0;
            q_acc.push_back(e);
        end
        mem_write       = wr;
        mem_read        = rd;
        mem_access_addr = addr;
        mem_write_data  = wdata;
        byte_en         = be;
        hc   = 0;
        done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (hold) hc++;
            else begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL hold_timeout addr=%h hold_cycles=%0d", addr, hc);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic push_dump(input int n);
        for (int i = 0; i < n; i++) begin
            q_dd.push_back(model[i]);
            q_da.push_back(4'(i));
        end
    endtask

    initial begin
        int hc;
        int n;
        bit seen;
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int hc;
        int n;
        bit seen;
        for (int i = 0; i < 16; i++) model[i] = '0;
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_access_addr = '0; mem_write_data = '0; byte_en = '0; dump_req = 1'b0;

        // Reset values; hold follows the request even in reset.
        repeat (2) @(negedge clk);
        check("rst_rd_data", mem_read_data, 32'h0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_addr_err", {31'b0, addr_err}, 32'h0);
        check("rst_dump_valid", {31'b0, dump_valid}, 32'h0);
        check("rst_dump_addr", {28'b0, dump_addr}, 32'h0);
        check("rst_dump_data", dump_data, 32'h0);
        check("rst_hold_idle", {31'b0, hold}, 32'h0);
        mem_read = 1'b1;
        #1 check("rst_hold_req", {31'b0, hold}, 32'h1);
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full-word write and read back.
        access(1, 0, 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, hc);
        check("hold_cycles_write", hc, 2);
        model[2] = 32'hDEADBEEF;
        access(0, 1, 32'h8, 0, 4'h0, 32'hDEADBEEF, 0, hc);
        check("hold_cycles_read", hc, 2);

        // Byte-lane merge.
        access(1, 0, 32'hC, 32'hAABBCCDD, 4'hF, 0, 0, hc);
        access(1, 0, 32'hC, 32'h11223344, 4'b0101, 0, 0, hc);
        model[3] = 32'hAA22CC44;
        access(0, 1, 32'hC, 0, 4'h0, 32'hAA22CC44, 0, hc);

        // Out-of-range read and write.
        access(0, 1, 32'h40, 0, 4'h0, 32'h0, 1, hc);
        check("oor_read_hold", hc, 2);
        access(1, 0, 32'h40, 32'h12345678, 4'hF, 0, 1, hc);

        // Read and write together is a write.
        access(1, 1, 32'h4, 32'h0BADF00D, 4'hF, 0, 0, hc);
        model[1] = 32'h0BADF00D;
        access(0, 1, 32'h4, 0, 4'h0, 32'h0BADF00D, 0, hc);

        // Read data holds across a write.
        access(1, 0, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, hc);
        model[0] = 32'hCAFEF00D;
        check("rd_data_hold", mem_read_data, 32'h0BADF00D);

        // Reset during the BUSY cycle of a write aborts it.
        mem_write = 1'b1; mem_access_addr = 32'h0; mem_write_data = 32'h5; byte_en = 4'hF;
        @(posedge clk);
        #2;
        reset = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check("abort_rd_data", mem_read_data, 32'h0);
        check("abort_hold", {31'b0, hold}, 32'h0);
        check("abort_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("abort_dump_valid", {31'b0, dump_valid}, 32'h0);
        @(negedge clk);
        check("abort_rd_valid2", {31'b0, rd_valid}, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1, 32'h0, 0, 4'h0, 32'hCAFEF00D, 0, hc);

        // Dump requested together with a read: the read completes first.
        push_dump(16);
        dump_req = 1'b1;
        access(0, 1, 32'h4, 0, 4'h0, 32'h0BADF00D, 0, hc);
        check("dump_vs_read_hold", hc, 2);
        n = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dump_valid) begin
                n++;
                seen = 1;
                dump_req = 1'b0;
            end else if (seen) break;
        end
        check("dump_len", n, 16);
        @(posedge clk);
        #1;

        // Write presented during a dump is stalled until the dump ends.
        push_dump(16);
        dump_req = 1'b1;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        access(1, 0, 32'h14, 32'h55AA55AA, 4'hF, 0, 0, hc);
        check("write_during_dump_hold", hc, 15);
        model[5] = 32'h55AA55AA;
        access(0, 1, 32'h14, 0, 4'h0, 32'h55AA55AA, 0, hc);

        // Reset during a dump stops it immediately.
        push_dump(2);
        dump_req = 1'b1;
        @(posedge clk);
        #1;
        dump_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("dump_rst_valid", {31'b0, dump_valid}, 32'h0);
        check("dump_rst_addr", {28'b0, dump_addr}, 32'h0);
        check("dump_rst_hold", {31'b0, hold}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("acc_queue_left", q_acc.size(), 0);
        check("dump_queue_left", q_dd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
